// File: rtl/regression_inverse.sv
// Inverse regression evaluator: recovers f0 = (y - c0 - cin) / c1
// with a restoring divider, one quotient bit per clock.
module regression_inverse #(
  parameter int YW = 32,
  parameter int FW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [YW-1:0] y,
  input  logic [YW-1:0] c0,
  input  logic [FW-1:0] c1,
  input  logic          cin,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] f0,
  output logic [FW-1:0] rem,
  output logic          sat,
  output logic          underflow,
  output logic          div_zero
);

  localparam int CW = $clog2(YW);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [FW-1:0] rp_q;
  logic [YW-1:0] quot_q;
  logic [FW-1:0] c1_q;
  logic [FW-1:0] f0_q;
  logic [FW-1:0] rem_q;
  logic          sat_q;
  logic          uf_q;
  logic          dz_q;

  logic [YW:0]   diff;
  logic [FW:0]   shl;
  logic [FW+1:0] trial;
  logic [FW-1:0] rp_d;
  logic [YW-1:0] quot_d;
  logic          unused_trial;

  always_comb begin
    diff = {1'b0, y} - {1'b0, c0} - {{YW{1'b0}}, cin};
    shl = {rp_q, quot_q[YW-1]};
    trial = {1'b0, shl} - {2'b00, c1_q};
    rp_d = shl[FW-1:0];
    quot_d = {quot_q[YW-2:0], 1'b0};
    // Non-negative trial: keep the subtraction and set the quotient bit.
    if (!trial[FW+1]) begin
      rp_d = trial[FW-1:0];
      quot_d = {quot_q[YW-2:0], 1'b1};
    end
  end

  assign unused_trial = trial[FW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rp_q    <= '0;
      quot_q  <= '0;
      c1_q    <= '0;
      f0_q    <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
      uf_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            c1_q <= c1;
            if (c1 == '0) begin
              state_q <= DONE;
              f0_q    <= '0;
              rem_q   <= '0;
              sat_q   <= 1'b0;
              uf_q    <= 1'b0;
              dz_q    <= 1'b1;
            end else if (diff[YW]) begin
              state_q <= DONE;
              f0_q    <= '0;
              rem_q   <= '0;
              sat_q   <= 1'b0;
              uf_q    <= 1'b1;
              dz_q    <= 1'b0;
            end else begin
              state_q <= DIV;
              cnt_q   <= CW'(YW - 1);
              rp_q    <= '0;
              quot_q  <= diff[YW-1:0];
            end
          end
        end
        DIV: begin
          rp_q   <= rp_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= DONE;
            rem_q   <= rp_d;
            uf_q    <= 1'b0;
            dz_q    <= 1'b0;
            if (|quot_d[YW-1:FW]) begin
              f0_q  <= '1;
              sat_q <= 1'b1;
            end else begin
              f0_q  <= quot_d[FW-1:0];
              sat_q <= 1'b0;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign f0        = f0_q;
  assign rem       = rem_q;
  assign sat       = sat_q;
  assign underflow = uf_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_regression_inverse.sv
// Directed vector bench for regression_inverse.
module tb_regression_inverse;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] y = '0;
  logic [31:0] c0 = '0;
  logic [15:0] c1 = '0;
  logic        cin = 1'b0;
  logic        busy, done, sat, underflow, div_zero;
  logic [15:0] f0, rem;

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;

  regression_inverse #(.YW(32), .FW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y(y), .c0(c0), .c1(c1), .cin(cin),
    .busy(busy), .done(done), .f0(f0), .rem(rem),
    .sat(sat), .underflow(underflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] y;
    logic [31:0] c0;
    logic [15:0] c1;
    logic        cin;
    logic [15:0] f0;
    logic [15:0] rem;
    logic        sat;
    logic        uf;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic launch(input logic [31:0] yy, input logic [31:0] cc0,
                        input logic [15:0] cc1, input logic ci);
    @(negedge clk);
    y = yy; c0 = cc0; c1 = cc1; cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int n, t1, t2;
    bit seen;
    vt[0]  = '{510000, 10000, 100, 0, 5000, 0, 0, 0, 0, 32};
    vt[1]  = '{510100, 10000, 100, 1, 5000, 99, 0, 0, 0, 32};
    vt[2]  = '{9999, 10000, 100, 0, 0, 0, 0, 1, 0, 0};
    vt[3]  = '{9999, 10000, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[4]  = '{7010000, 10000, 100, 0, 65535, 0, 1, 0, 0, 32};
    vt[5]  = '{10100, 10000, 100, 0, 1, 0, 0, 0, 0, 32};
    vt[6]  = '{10001, 10000, 100, 1, 0, 0, 0, 0, 0, 32};
    vt[7]  = '{10000, 10000, 100, 1, 0, 0, 0, 1, 0, 0};
    vt[8]  = '{65535, 0, 1, 0, 65535, 0, 0, 0, 0, 32};
    vt[9]  = '{65536, 0, 1, 0, 65535, 0, 1, 0, 0, 32};
    vt[10] = '{1000, 1, 7, 0, 142, 5, 0, 0, 0, 32};
    vt[11] = '{32'hFFFF_FFFF, 0, 16'hFFFF, 0, 65535, 0, 1, 0, 0, 32};
    vt[12] = '{32'h1234_5678, 0, 16'h1234, 0, 65535, 3496, 1, 0, 0, 32};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_f0", f0, 0);
    chk("rst_flags", {sat, underflow, div_zero}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      launch(vt[i].y, vt[i].c0, vt[i].c1, vt[i].cin);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_done(n);
      chk($sformatf("v%0d_lat", i), n, vt[i].lat);
      chk($sformatf("v%0d_f0", i), f0, vt[i].f0);
      chk($sformatf("v%0d_rem", i), rem, vt[i].rem);
      chk($sformatf("v%0d_sat", i), sat, vt[i].sat);
      chk($sformatf("v%0d_uf", i), underflow, vt[i].uf);
      chk($sformatf("v%0d_dz", i), div_zero, vt[i].dz);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle", i), {busy, done}, 0);
      chk($sformatf("v%0d_hold", i), f0, vt[i].f0);
    end

    // Start pulse and input change mid-division are ignored.
    launch(510000, 10000, 100, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    y = 20000; c1 = 3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk("ign_lat", n, 22);
    chk("ign_f0", f0, 5000);
    chk("ign_rem", rem, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_noq", busy, 0);

    // start held high: back-to-back every 34 cycles.
    @(negedge clk);
    y = 510100; c0 = 10000; c1 = 100; cin = 1; start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n);
    t1 = cyc;
    chk("b2b_lat1", n, 32);
    @(posedge clk);
    #1;
    wait_done(n);
    t2 = cyc;
    start = 1'b0;
    chk("b2b_gap", t2 - t1, 34);
    chk("b2b_f0", f0, 5000);
    chk("b2b_rem", rem, 99);
    @(posedge clk);
    #1;

    // Reset mid-division aborts with no done pulse.
    launch(510000, 10000, 100, 0);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_f0", f0, 0);
    chk("abort_rem", rem, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    chk("abort_nodone", seen, 0);
    chk("abort_f0_hold", f0, 0);

    launch(510100, 10000, 100, 1);
    wait_done(n);
    chk("post_lat", n, 32);
    chk("post_f0", f0, 5000);
    chk("post_rem", rem, 99);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
